// File: rtl/wb_io_bridge.sv
// Wishbone-slave I/O bridge: decodes I/O cycles onto NCH chip selects, generates
// IOR_N/IOW_N strobes with wait states, per-channel ready and a bus timeout.
module wb_io_bridge #(
  parameter int NCH      = 8,
  parameter int CH_LSB   = 4,
  parameter int PAGE_MSB = 9,
  parameter int WAIT     = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [19:1]       wb_adr_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  input  logic [1:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_tga_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [NCH-1:0]    io_cs_n,
  output logic              io_ior_n,
  output logic              io_iow_n,
  output logic              io_adr,
  output logic [1:0]        io_sel,
  output logic [15:0]       io_dat_o,
  input  logic [16*NCH-1:0] io_dat_i,
  input  logic [NCH-1:0]    io_rdy_i,
  output logic              err_o
);

  localparam int CHW = $clog2(NCH);
  localparam int PG_LSB = CH_LSB + CHW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] WAIT_C = 4'(WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;
  state_t state_reg, state_next;

  logic [CHW-1:0] ch_reg, ch_next;
  logic           we_reg, we_next;
  logic           adr_reg, adr_next;
  logic [1:0]     sel_reg, sel_next;
  logic [15:0]    wdat_reg, wdat_next;
  logic [15:0]    rdat_reg, rdat_next;
  logic           err_reg, err_next;
  logic [3:0]     wait_cnt_reg, wait_cnt_next;
  logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [NCH-1:0] cs_n_reg, cs_n_next;
  logic           ior_n_reg, ior_n_next;
  logic           iow_n_reg, iow_n_next;
  logic           ack_reg, ack_next;

  logic           req;
  logic           page_miss;
  logic [CHW-1:0] ch_sel;
  logic [NCH-1:0] cs_dec;
  logic [15:0]    ch_dat [NCH];
  logic           rdy_sel;
  logic           wait_done;
  logic           tmo_hit;
  logic           unused_adr;

  assign req       = wb_cyc_i & wb_stb_i & wb_tga_i;
  assign ch_sel    = wb_adr_i[CH_LSB +: CHW];
  assign rdy_sel   = io_rdy_i[ch_reg];
  assign wait_done = (wait_cnt_reg == WAIT_C);
  assign tmo_hit   = (tmo_cnt_reg == TMO_LAST);
  assign unused_adr = ^wb_adr_i;

  // Any set bit in the page field above the channel index marks an unmapped port.
  generate
    if (PAGE_MSB >= PG_LSB) begin : g_page
      assign page_miss = |wb_adr_i[PAGE_MSB:PG_LSB];
    end else begin : g_nopage
      assign page_miss = 1'b0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign cs_dec[gi] = (ch_sel == CHW'(gi));
      assign ch_dat[gi] = io_dat_i[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Dropping wb_cyc_i abandons the access and wins over a same-cycle completion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (req) state_next = page_miss ? ACK : SETUP;
      SETUP:  state_next = wb_cyc_i ? STROBE : IDLE;
      STROBE: begin
        if (!wb_cyc_i)                  state_next = IDLE;
        else if (wait_done && rdy_sel)  state_next = ACK;
        else if (tmo_hit)               state_next = ACK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ch_next       = ch_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    sel_next      = sel_reg;
    wdat_next     = wdat_reg;
    rdat_next     = rdat_reg;
    err_next      = err_reg;
    wait_cnt_next = wait_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req && page_miss) begin
          rdat_next = 16'hFFFF;
          err_next  = 1'b1;
        end else if (req) begin
          ch_next   = ch_sel;
          we_next   = wb_we_i;
          adr_next  = wb_adr_i[1];
          sel_next  = wb_sel_i;
          wdat_next = wb_dat_i;
        end
      end
      SETUP: begin
        wait_cnt_next = '0;
        tmo_cnt_next  = '0;
      end
      STROBE: begin
        if (wb_cyc_i) begin
          wait_cnt_next = wait_done ? wait_cnt_reg : wait_cnt_reg + 4'd1;
          tmo_cnt_next  = tmo_cnt_reg + TW'(1);
          if (wait_done && rdy_sel) begin
            if (!we_reg) rdat_next = ch_dat[ch_reg];
          end else if (tmo_hit) begin
            rdat_next = 16'hFFFF;
            err_next  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Chip select is held through ACK so the peripheral sees stable address/data.
    if (state_next == IDLE)
      cs_n_next = '1;
    else if (state_reg == IDLE)
      cs_n_next = (state_next == SETUP) ? ~cs_dec : '1;
    else
      cs_n_next = cs_n_reg;

    ior_n_next = !((state_next == STROBE) && !we_next);
    iow_n_next = !((state_next == STROBE) && we_next);
    ack_next   = (state_next == ACK);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ch_reg       <= '0;
      we_reg       <= 1'b0;
      adr_reg      <= 1'b0;
      sel_reg      <= '0;
      wdat_reg     <= '0;
      rdat_reg     <= '0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      cs_n_reg     <= '1;
      ior_n_reg    <= 1'b1;
      iow_n_reg    <= 1'b1;
      ack_reg      <= 1'b0;
    end else begin
      ch_reg       <= ch_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      sel_reg      <= sel_next;
      wdat_reg     <= wdat_next;
      rdat_reg     <= rdat_next;
      err_reg      <= err_next;
      wait_cnt_reg <= wait_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      cs_n_reg     <= cs_n_next;
      ior_n_reg    <= ior_n_next;
      iow_n_reg    <= iow_n_next;
      ack_reg      <= ack_next;
    end
  end

  assign wb_dat_o = rdat_reg;
  assign wb_ack_o = ack_reg;
  assign io_cs_n  = cs_n_reg;
  assign io_ior_n = ior_n_reg;
  assign io_iow_n = iow_n_reg;
  assign io_adr   = adr_reg;
  assign io_sel   = sel_reg;
  assign io_dat_o = wdat_reg;
  assign err_o    = err_reg;

endmodule
